// File: rtl/const_unit_ext.sv
// Registered immediate-extension unit: sign/zero-extends a final immediate, optionally
// prefixed by earlier words, to DATA_W bits. Prefix support is enabled by CONST_UNIT_PREFIX_EN.
module const_unit_ext #(
  parameter int IMM_W      = 6,
  parameter int DATA_W     = 16,
  parameter int MAX_PREFIX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              prefix,
  input  logic              cs,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] const_out,
  output logic              prefix_pending,
  output logic              prefix_ovf
);

  localparam int ACC_W = MAX_PREFIX * IMM_W;
  localparam int TOT_W = ACC_W + IMM_W;
  localparam int EXT_W = (TOT_W > DATA_W) ? TOT_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_PREFIX + 1);

  // Extend the low n bits of raw: bit n-1 is replicated upward when sgn is set.
  function automatic logic [EXT_W-1:0] extend_f(input logic [EXT_W-1:0] raw, input int n,
                                                input logic sgn);
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] one;
    one  = {{(EXT_W-1){1'b0}}, 1'b1};
    mask = {EXT_W{1'b1}} >> (EXT_W - n);
    if (sgn && ((raw & (one << (n - 1))) != {EXT_W{1'b0}})) begin
      return raw | ~mask;
    end else begin
      return raw & mask;
    end
  endfunction

  logic              final_accept_s;
  logic [EXT_W-1:0]  raw_s;
  logic [EXT_W-1:0]  ext_s;
  int                n_s;
  logic              out_valid_r;
  logic [DATA_W-1:0] const_r;

`ifdef CONST_UNIT_PREFIX_EN
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             prefix_accept_s;
  logic [TOT_W-1:0] cat_s;

  assign cat_s           = {acc_r, imm_in};
  assign prefix_accept_s = in_valid & prefix & ~flush;
  assign final_accept_s  = in_valid & ~prefix & ~flush;
  assign raw_s           = EXT_W'(cat_s);

  // Prefix accumulator next state; a full accumulator drops its oldest word.
  always_comb begin
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = 1'b0;
    if (flush || final_accept_s) begin
      acc_nxt_s = {ACC_W{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (prefix_accept_s) begin
      acc_nxt_s = cat_s[ACC_W-1:0];
      if (cnt_r == CNT_W'(MAX_PREFIX)) begin
        ovf_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Raw field width grows by one word per pending prefix.
  always_comb begin
    n_s = (int'(cnt_r) + 1) * IMM_W;
  end

  // Prefix state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign prefix_pending = (cnt_r != {CNT_W{1'b0}});
  assign prefix_ovf     = ovf_r;
`else
  // The prefix flag has no effect in this build; every valid word is final.
  assign final_accept_s = in_valid & ~flush & (prefix | ~prefix);
  assign raw_s          = EXT_W'(imm_in);

  // Fixed single-word field width.
  always_comb begin
    n_s = IMM_W;
  end

  assign prefix_pending = 1'b0;
  assign prefix_ovf     = 1'b0;
`endif

  // Extension of the assembled field.
  always_comb begin
    ext_s = extend_f(raw_s, n_s, cs);
  end

  // Output registers; const_out holds until the next final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      const_r     <= {DATA_W{1'b0}};
    end else begin
      out_valid_r <= final_accept_s;
      if (final_accept_s) begin
        const_r <= ext_s[DATA_W-1:0];
      end
    end
  end

  assign out_valid = out_valid_r;
  assign const_out = const_r;

endmodule

// File: tb/tb_const_unit_ext.sv
// Table-driven scoreboard bench for const_unit_ext (default parameters); expectations
// follow CONST_UNIT_PREFIX_EN when it is defined.
module tb_const_unit_ext;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  imm_in = 6'h00;
  logic        prefix = 1'b0;
  logic        cs = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] const_out;
  logic        prefix_pending;
  logic        prefix_ovf;

  typedef struct {
    logic        v;
    logic [5:0]  imm;
    logic        pfx;
    logic        cs;
    logic        fl;
    logic        ov;
    logic [15:0] val;
    logic        pend;
    logic        ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] last_val = 16'h0000;
  int          n_cmp = 0;
  int          n_bad = 0;

  const_unit_ext dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .imm_in(imm_in), .prefix(prefix),
    .cs(cs), .flush(flush), .out_valid(out_valid), .const_out(const_out),
    .prefix_pending(prefix_pending), .prefix_ovf(prefix_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [15:0] exp_val;
    in_valid = t.v; imm_in = t.imm; prefix = t.pfx; cs = t.cs; flush = t.fl;
    if (t.ov) sb.push_back(t.val);
    @(posedge clk); #1;
    chk($sformatf("out_valid[%0d]", idx), {15'h0000, out_valid}, {15'h0000, sb.size() > 0});
    if (sb.size() > 0) begin
      exp_val = sb.pop_front();
      last_val = exp_val;
    end else begin
      exp_val = last_val;
    end
    chk($sformatf("const_out[%0d]", idx), const_out, exp_val);
    chk($sformatf("pending[%0d]", idx), {15'h0000, prefix_pending}, {15'h0000, t.pend});
    chk($sformatf("ovf[%0d]", idx), {15'h0000, prefix_ovf}, {15'h0000, t.ovf});
    in_valid = 1'b0; flush = 1'b0; prefix = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, {15'h0000, out_valid}, 16'h0000);
    chk({tag, "_const_out"}, const_out, 16'h0000);
    chk({tag, "_pending"}, {15'h0000, prefix_pending}, 16'h0000);
    chk({tag, "_ovf"}, {15'h0000, prefix_ovf}, 16'h0000);
  endtask

  initial begin
    //                v     imm    pfx   cs    fl    ov    val       pend  ovf
    vecs.push_back('{1'b1, 6'h21, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFE1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h21, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0021, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFE0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h1F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h001F, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h05, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
`ifdef CONST_UNIT_PREFIX_EN
    vecs.push_back('{1'b1, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h05, 1'b0, 1'b1, 1'b0, 1'b1, 16'hF845, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1FFF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    // {01,02,00} = 18'h01080, low 16 bits kept
    vecs.push_back('{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1080, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h05, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h05, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h21, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h007F, 1'b0, 1'b0});
`else
    vecs.push_back('{1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFE1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1, 16'h003F, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 6'h15, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0015, 1'b0, 1'b0});
`endif

    #2;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-sequence: outputs clear immediately, without a clock edge.
`ifdef CONST_UNIT_PREFIX_EN
    apply('{1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0}, 100);
`else
    apply('{1'b1, 6'h21, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFE1, 1'b0, 1'b0}, 100);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    sb.delete();
    last_val = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    apply('{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0}, 101);
    apply('{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}, 102);

    chk("sb_drained", 16'(sb.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
